display_scan: RTL

Time-multiplexed 7-segment scan driver that consumes the packed 4-bit digit-code bus produced by the time-of-day counter and drives one digit at a time onto a shared segment bus. Digit codes 0–9 display as numerals, code 10 as a separator dash, and codes 11–15 as blank. The input bus is snapshotted once per frame so a counter rollover mid-scan never tears the display. The block sits between the clock/counter stage and the board's segment and anode pins.

---
 rtl/disp_pkg.sv | 32 +++
 rtl/seg_decoder.sv | 29 ++
 rtl/display_scan.sv | 124 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the 7-segment scan path.
//   Segment patterns are {g,f,e,d,c,b,a}, active-high.
//   SEP_CODE / BLANK_CODE are also used by the time-of-day counter stage.
//   Optional feature macro: DISP_GHOST_GUARD_EN (adds the GUARD state).
package disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_SEP   = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] SEP_CODE   = 4'd10;
   localparam logic [3:0] BLANK_CODE = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1
`ifdef DISP_GHOST_GUARD_EN
      ,
      ST_GUARD = 2'd2
`endif
   } disp_state_e;

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational digit-code to segment-pattern map.
//   code_i  in  4  digit code (0-9 numeral, 10 separator, 11-15 blank)
//   seg_o   out 7  segment pattern {g,f,e,d,c,b,a}, active-high
module seg_decoder
   import disp_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'd0:     seg_o = SEG_0;
         4'd1:     seg_o = SEG_1;
         4'd2:     seg_o = SEG_2;
         4'd3:     seg_o = SEG_3;
         4'd4:     seg_o = SEG_4;
         4'd5:     seg_o = SEG_5;
         4'd6:     seg_o = SEG_6;
         4'd7:     seg_o = SEG_7;
         4'd8:     seg_o = SEG_8;
         4'd9:     seg_o = SEG_9;
         SEP_CODE: seg_o = SEG_SEP;
         default:  seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scan driver.
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             asynchronous active-low reset
//   num_data     in   4*NUM_DIGITS  packed digit codes, digit i = num_data[4*i +: 4]
//   seg          out  7             segment drive {g,f,e,d,c,b,a}, registered
//   an           out  NUM_DIGITS    one-hot digit enable, registered
//   frame_start  out  1             pulse on the first cycle digit 0 is lit
// Optional feature macro: DISP_GHOST_GUARD_EN inserts GUARD_CYCLES of
// all-off blanking after every digit.
//
// state | meaning
// IDLE  | out of reset, first edge starts a frame at digit 0
// SHOW  | current digit lit for SCAN_DIV cycles
// GUARD | all anodes off for GUARD_CYCLES (guard build only)
module display_scan
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS   = 11,
   parameter int SCAN_DIV     = 8,
   parameter int GUARD_CYCLES = 1
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] num_data,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CMAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] SHOW_TC  = CW'(SCAN_DIV - 1);
`ifdef DISP_GHOST_GUARD_EN
   localparam logic [CW-1:0] GUARD_TC = CW'(GUARD_CYCLES - 1);
`endif

   disp_state_e             state_q;
   logic [IW-1:0]           idx_q;
   logic [CW-1:0]           cnt_q;
   logic [4*NUM_DIGITS-1:0] snap_q;
   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    frame_start_q;

   logic                    slot_start;
   logic                    wrap;
   logic [IW-1:0]           idx_d;
   logic [3:0]              code_d;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;

   // A new frame starts out of IDLE or after the last digit; in both cases
   // digit 0 comes straight from the live bus, which is snapshotted on the
   // same edge so the rest of the frame cannot tear.
   always_comb begin
      wrap  = (state_q == ST_IDLE) || (idx_q == LAST_IDX);
      idx_d = wrap ? '0 : idx_q + 1'b1;
      an_d  = NUM_DIGITS'(1) << idx_d;

      code_d = num_data[3:0];
      if (!wrap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) code_d = snap_q[4*i +: 4];
         end
      end

      slot_start = 1'b0;
      case (state_q)
         ST_IDLE:  slot_start = 1'b1;
`ifdef DISP_GHOST_GUARD_EN
         ST_GUARD: slot_start = (cnt_q == GUARD_TC);
`else
         ST_SHOW:  slot_start = (cnt_q == SHOW_TC);
`endif
         default:  slot_start = 1'b0;
      endcase
   end

   seg_decoder u_dec (
      .code_i (code_d),
      .seg_o  (seg_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         snap_q        <= '1;
         seg_q         <= '0;
         an_q          <= '0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         cnt_q         <= cnt_q + 1'b1;
         if (slot_start) begin
            state_q       <= ST_SHOW;
            cnt_q         <= '0;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= wrap;
            if (wrap) snap_q <= num_data;
         end
`ifdef DISP_GHOST_GUARD_EN
         else if (state_q == ST_SHOW && cnt_q == SHOW_TC) begin
            state_q <= ST_GUARD;
            cnt_q   <= '0;
            an_q    <= '0;
            seg_q   <= '0;
         end
`endif
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule
